serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, sampled only on accept.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, sampled only on accept.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a start will be accepted.
REQ-008 The block SHALL have port diff, output, WIDTH bits: result a-b.
REQ-009 The block SHALL have port borrow, output, 1 bit: final borrow-out; 1 means a<b unsigned.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking diff and borrow valid.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 The block SHALL accept a request only on a rising edge where start=1 and ready=1; that edge is the accepting edge.
REQ-013 On the accepting edge the block SHALL load a and b into shift registers, clear the borrow flop and the bit counter, and enter RUN.
REQ-014 ready SHALL be 1 in IDLE and 0 in RUN and DONE; start outside IDLE SHALL be ignored with no effect.
REQ-015 In RUN the block SHALL process one bit per edge, LSB first: diff bit = a_i XOR b_i XOR bin; bout = (~a_i & b_i) | (~(a_i XOR b_i) & bin).
REQ-016 The block SHALL shift result bits into diff MSB-side, so that after WIDTH RUN edges diff holds the full result in natural bit order.
REQ-017 The counter SHALL advance 0..WIDTH-1; on the edge processing bit WIDTH-1 the FSM SHALL enter DONE and borrow SHALL capture the final bout.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle, WIDTH clock edges after the accepting edge; the next edge SHALL return the FSM to IDLE.
REQ-019 diff and borrow SHALL hold their last values from DONE until the next accepting edge, and need not be meaningful during RUN.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH; the block SHALL use no carry-in and no sign handling.
REQ-021 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle directly after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-022 rst=1 on a rising edge SHALL force IDLE, ready=1, done=0, diff=0, borrow=0, counter=0, and borrow flop=0, taking priority over start.
REQ-023 rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first accept is possible on the edge after rst deasserts.

Configuration
REQ-024 When SERIAL_SUB_SAT_EN is defined, a final borrow=1 SHALL force diff to all zeros in DONE (saturating subtraction), with borrow still reported as 1.
REQ-025 When SERIAL_SUB_SAT_EN is undefined, diff SHALL be the wrapped modulo 2^WIDTH result and no saturation logic SHALL be present.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width function clog2(WIDTH).
REQ-027 The per-bit full-subtract logic SHALL be built from one sub-module hsub (half subtractor: d=x^y, bo=~x&y) instantiated twice with an OR for bout; there SHALL be no other sub-modules.

Verification
REQ-028 The bench SHALL cover: WIDTH=8, a=5, b=3, start pulsed -> done 8 edges after accept, diff=8'h02, borrow=0.
REQ-029 The bench SHALL cover: a=3, b=5 -> diff=8'hFE, borrow=1; with SERIAL_SUB_SAT_EN -> diff=8'h00, borrow=1.
REQ-030 The bench SHALL cover: a=8'hFF, b=8'hFF, then a=8'h00, b=8'h00 -> diff=0, borrow=0 both times; a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1 (no SAT).
REQ-031 The bench SHALL cover: start=1 with a=9, b=4 held through RUN while a and b change -> a single result diff=8'h05, ready=0 throughout RUN, and exactly one done pulse per accept.
REQ-032 The bench SHALL cover: rst asserted at RUN cycle 4 -> no done pulse, outputs zero, ready=1 on the next cycle; a new a=7, b=2 request -> diff=8'h05.
REQ-033 The bench SHALL cover: start held high continuously for 3 operations -> done pulses spaced 10 cycles apart, each with the correct result.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared constants for the bit-serial subtractor.
//   - FSM state encodings (IDLE / RUN / DONE), 2-bit legacy-compatible values
//   - clog2(): ceiling log2 used to size the bit counter
// No ports (package).
// -----------------------------------------------------------------------------
package serial_sub_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Ceiling log2; returns at least 1 for any value >= 2.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_sub_hsub.sv
// -----------------------------------------------------------------------------
// hsub -- half subtractor, x - y.
// Ports:
//   i_x  : minuend bit
//   i_y  : subtrahend bit
//   o_d  : difference bit (x ^ y)
//   o_bo : borrow out (~x & y)
// -----------------------------------------------------------------------------
module hsub (
   input  logic i_x,
   input  logic i_y,
   output logic o_d,
   output logic o_bo
);

   assign o_d  = i_x ^ i_y;
   assign o_bo = ~i_x & i_y;

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub -- bit-serial unsigned subtractor, diff = a - b (mod 2^WIDTH).
// One bit per clock, LSB first; a result takes WIDTH RUN cycles plus one DONE
// cycle, and the FSM spends one IDLE cycle before the next accept.
// Build option: define SERIAL_SUB_SAT_EN for saturating subtraction (a final
// borrow forces diff to zero; borrow is still reported).
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request; accepted when start & ready on a rising edge
//   a, b   : minuend / subtrahend, sampled only on the accepting edge
//   ready  : high in IDLE
//   diff   : result, valid while done=1 and held until the next accept
//   borrow : final borrow out (1 when a < b)
//   done   : one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             done
);

   localparam int unsigned          CNT_W    = clog2(WIDTH);
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_bin;
   logic [CNT_W-1:0] r_cnt;

   logic             w_d1;
   logic             w_bo1;
   logic             w_d;
   logic             w_bo2;
   logic             w_bout;

   // Full subtractor from two half subtractors: (a_i - b_i) - bin.
   hsub u_hsub_ab (
      .i_x  (r_a[0]),
      .i_y  (r_b[0]),
      .o_d  (w_d1),
      .o_bo (w_bo1)
   );

   hsub u_hsub_bin (
      .i_x  (w_d1),
      .i_y  (r_bin),
      .o_d  (w_d),
      .o_bo (w_bo2)
   );

   assign w_bout = w_bo1 | w_bo2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bin    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_bin   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a    <= r_a >> 1;
               r_b    <= r_b >> 1;
               r_bin  <= w_bout;
               // Result bits enter at the MSB and walk down, so after WIDTH
               // shifts bit 0 has reached the LSB.
               r_diff <= {w_d, r_diff[WIDTH-1:1]};
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_BIT) begin
                  r_state  <= DONE;
                  r_borrow <= w_bout;
`ifdef SERIAL_SUB_SAT_EN
                  if (w_bout) r_diff <= '0;
`endif
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ready  = (r_state == IDLE);
   assign done   = (r_state == DONE);
   assign diff   = r_diff;
   assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub -- self-checking bench for serial_sub (WIDTH=8).
// Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         done;

   int errors;
   int checks;
   int cyc;

   serial_sub #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .diff   (diff),
      .borrow (borrow),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: unsigned subtraction with borrow out; optional saturation.
   function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned xi;
      int unsigned yi;
      logic [W-1:0] d;
      logic         bo;
      xi = int'(x);
      yi = int'(y);
      bo = (xi < yi);
      d  = W'((xi + (1 << W) - yi) % (1 << W));
`ifdef SERIAL_SUB_SAT_EN
      if (bo) d = '0;
`endif
      return {bo, d};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for done, counting edges; flags ready high while waiting.
   task automatic wait_done(output int n, output bit rdy_bad);
      n = 0;
      rdy_bad = 1'b0;
      while (n < 40) begin
         tick();
         n++;
         if (done === 1'b1) break;
         if (ready !== 1'b0) rdy_bad = 1'b1;
      end
   endtask

   // Single directed operation: pulse start, check latency, result, pulse width.
   task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
      int  n;
      bit  rb;
      logic [W:0] e;
      e = ref_sub(x, y);
      chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
      a = x;
      b = y;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      chk({tag, "_ready_run"}, 32'(ready), 32'd0);
      wait_done(n, rb);
      chk({tag, "_latency"}, 32'(n), 32'(W));
      chk({tag, "_ready_low"}, 32'(rb), 32'd0);
      chk({tag, "_diff"}, 32'(diff), 32'(e[W-1:0]));
      chk({tag, "_borrow"}, 32'(borrow), 32'(e[W]));
      tick();
      chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
      chk({tag, "_ready_post"}, 32'(ready), 32'd1);
      chk({tag, "_diff_hold"}, 32'(diff), 32'(e[W-1:0]));
   endtask

   initial begin
      int          n;
      bit          rb;
      int          pulses;
      int          t_done [3];
      logic [W-1:0] oa [3];
      logic [W-1:0] ob [3];
      logic [W:0]  e;

      errors = 0;
      checks = 0;
      rst = 1'b1;
      start = 1'b1;
      a = 8'hAA;
      b = 8'h55;
      tick();
      tick();
      // Reset state, with start held high to show reset priority.
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      tick();

      do_op("5m3", 8'd5, 8'd3);
      do_op("3m5", 8'd3, 8'd5);
      do_op("ffmff", 8'hFF, 8'hFF);
      do_op("0m0", 8'h00, 8'h00);
      do_op("0m1", 8'h00, 8'h01);

      // start held through RUN while operands change: one result, one done.
      a = 8'd9;
      b = 8'd4;
      start = 1'b1;
      tick();
      pulses = 0;
      rb = 1'b0;
      n = 0;
      while (n < 40) begin
         a = W'($urandom);
         b = W'($urandom);
         tick();
         n++;
         if (done === 1'b1) break;
         if (ready !== 1'b0) rb = 1'b1;
      end
      start = 1'b0;
      chk("hold_latency", 32'(n), 32'(W));
      chk("hold_ready_low", 32'(rb), 32'd0);
      chk("hold_diff", 32'(diff), 32'h05);
      chk("hold_borrow", 32'(borrow), 32'd0);
      for (int i = 0; i < 14; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      chk("hold_extra_done", 32'(pulses), 32'd0);

      // Abort mid-RUN: leave a nonzero result first so the clear is visible.
      do_op("200m1", 8'd200, 8'd1);
      a = 8'd3;
      b = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_borrow", 32'(borrow), 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
      do_op("7m2", 8'd7, 8'd2);

      // Back-to-back: start held for three operations.
      oa[0] = 8'd100; ob[0] = 8'd37;
      oa[1] = 8'd12;  ob[1] = 8'd200;
      oa[2] = 8'd255; ob[2] = 8'd0;
      a = oa[0];
      b = ob[0];
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_done(n, rb);
         chk("b2b_done_seen", 32'(done), 32'd1);
         t_done[k] = cyc;
         e = ref_sub(oa[k], ob[k]);
         chk("b2b_diff", 32'(diff), 32'(e[W-1:0]));
         chk("b2b_borrow", 32'(borrow), 32'(e[W]));
         if (k < 2) begin
            a = oa[k+1];
            b = ob[k+1];
         end else begin
            start = 1'b0;
         end
      end
      chk("b2b_space1", 32'(t_done[1] - t_done[0]), 32'(W + 2));
      chk("b2b_space2", 32'(t_done[2] - t_done[1]), 32'(W + 2));
      tick();
      tick();

      // Random operations against the reference model.
      for (int i = 0; i < 20; i++) begin
         do_op("rand", W'($urandom), W'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
